// File: rtl/texture_loader_pkg.sv
// Shared game package: asset size constants and the texture loader state
// encoding. The renderer imports the same constants, so the loader and the
// texture memories always agree on the asset geometry.
package texture_loader_pkg;

    localparam int BIRD_WORDS = 5250;   // 3 bird frames, each 50x35
    localparam int PIPE_WORDS = 40000;  // pipe source image, 80x500
    localparam int BASE_SRC_W = 64;     // base source width in pixels
    localparam int BASE_TEX_W = 32;     // stored base width, power of 2
    localparam int BASE_H     = 150;    // base rows

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_BIRD = 3'd1,
        LD_PIPE = 3'd2,
        LD_BASE = 3'd3,
        LD_DONE = 3'd4
    } loader_state_e;

endpackage

// File: rtl/texture_loader.sv
// texture_loader
// Streams RGB565 words from the SDRAM reader into the bird, pipe and base
// texture memories, in that order, after a start pulse.
//
// Ports
//   bird_load_clk  clock for all logic
//   rst_n          asynchronous active-low reset
//   start          single-cycle pulse, begins a load (ignored while busy)
//   src_data       RGB565 source word
//   src_valid      src_data is valid
//   src_ready      loader accepts src_data (high in BIRD/PIPE/BASE)
//   bird_load_en   bird write strobe,  bird_load_addr 13-bit address
//   bird_load_data write data shared by all three targets
//   pipe_load_en   pipe write strobe,  pipe_load_addr 16-bit address
//   base_load_en   base write strobe,  base_load_addr 14-bit address
//   busy           a load sequence is in progress
//   done           level, all assets loaded
module texture_loader
    import texture_loader_pkg::*;
#(
    parameter int BIRD_WORDS = texture_loader_pkg::BIRD_WORDS,
    parameter int PIPE_WORDS = texture_loader_pkg::PIPE_WORDS,
    parameter int BASE_SRC_W = texture_loader_pkg::BASE_SRC_W,
    parameter int BASE_TEX_W = texture_loader_pkg::BASE_TEX_W,
    parameter int BASE_H     = texture_loader_pkg::BASE_H
) (
    input  logic        bird_load_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        bird_load_en,
    output logic [12:0] bird_load_addr,
    output logic [15:0] bird_load_data,
    output logic        pipe_load_en,
    output logic [15:0] pipe_load_addr,
    output logic        base_load_en,
    output logic [13:0] base_load_addr,
    output logic        busy,
    output logic        done
);

    localparam logic [12:0] BIRD_LAST = 13'(BIRD_WORDS - 1);
    localparam logic [15:0] PIPE_LAST = 16'(PIPE_WORDS - 1);
    localparam logic [5:0]  COL_LAST  = 6'(BASE_SRC_W - 1);
    localparam logic [7:0]  ROW_LAST  = 8'(BASE_H - 1);

    loader_state_e state_q, state_d;
    logic [12:0]   bird_cnt_q, bird_cnt_d;
    logic [15:0]   pipe_cnt_q, pipe_cnt_d;
    logic [5:0]    col_q, col_d;
    logic [7:0]    row_q, row_d;
    logic          bird_en_q, bird_en_d;
    logic          pipe_en_q, pipe_en_d;
    logic          base_en_q, base_en_d;
    logic [12:0]   bird_addr_q, bird_addr_d;
    logic [15:0]   pipe_addr_q, pipe_addr_d;
    logic [13:0]   base_addr_q, base_addr_d;
    logic [15:0]   data_q, data_d;
    logic          done_q, done_d;

    logic          loading;
    logic          accept;

    assign loading = (state_q == LD_BIRD) || (state_q == LD_PIPE) || (state_q == LD_BASE);
    assign accept  = src_valid && loading;

    always_comb begin
        // NOTE: every _d takes its hold value before any branch, so no path
        // through this block leaves a signal unassigned and infers a latch.
        state_d     = state_q;
        bird_cnt_d  = bird_cnt_q;
        pipe_cnt_d  = pipe_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        bird_en_d   = 1'b0;
        pipe_en_d   = 1'b0;
        base_en_d   = 1'b0;
        bird_addr_d = bird_addr_q;
        pipe_addr_d = pipe_addr_q;
        base_addr_d = base_addr_q;
        data_d      = data_q;
        done_d      = done_q;

        if (accept) begin
            data_d = src_data;
        end

        unique case (state_q)
            LD_IDLE, LD_DONE: begin
                // done rises the cycle after DONE is entered and stays high
                // until the start that launches the next sequence.
                if (state_q == LD_DONE) begin
                    done_d = 1'b1;
                end
                if (start) begin
                    state_d    = LD_BIRD;
                    bird_cnt_d = '0;
                    done_d     = 1'b0;
                end
            end
            LD_BIRD: begin
                if (accept) begin
                    bird_en_d   = 1'b1;
                    bird_addr_d = bird_cnt_q;
                    if (bird_cnt_q == BIRD_LAST) begin
                        state_d    = LD_PIPE;
                        pipe_cnt_d = '0;
                    end else begin
                        bird_cnt_d = bird_cnt_q + 13'd1;
                    end
                end
            end
            LD_PIPE: begin
                if (accept) begin
                    pipe_en_d   = 1'b1;
                    pipe_addr_d = pipe_cnt_q;
                    if (pipe_cnt_q == PIPE_LAST) begin
                        state_d = LD_BASE;
                        col_d   = '0;
                        row_d   = '0;
                    end else begin
                        pipe_cnt_d = pipe_cnt_q + 16'd1;
                    end
                end
            end
            LD_BASE: begin
                if (accept) begin
                    // Only the left BASE_TEX_W columns are stored; the rest of
                    // each source row is consumed and dropped.
                    if (int'(col_q) < BASE_TEX_W) begin
                        base_en_d   = 1'b1;
                        base_addr_d = 14'(int'(row_q) * BASE_TEX_W + int'(col_q));
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = LD_DONE;
                        end else begin
                            row_d = row_q + 8'd1;
                        end
                    end else begin
                        col_d = col_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and the
    // asynchronous reset clears every flop so an aborted load leaves nothing
    // half-driven.
    always_ff @(posedge bird_load_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LD_IDLE;
            bird_cnt_q  <= '0;
            pipe_cnt_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            bird_en_q   <= 1'b0;
            pipe_en_q   <= 1'b0;
            base_en_q   <= 1'b0;
            bird_addr_q <= '0;
            pipe_addr_q <= '0;
            base_addr_q <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bird_cnt_q  <= bird_cnt_d;
            pipe_cnt_q  <= pipe_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            bird_en_q   <= bird_en_d;
            pipe_en_q   <= pipe_en_d;
            base_en_q   <= base_en_d;
            bird_addr_q <= bird_addr_d;
            pipe_addr_q <= pipe_addr_d;
            base_addr_q <= base_addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    assign src_ready      = loading;
    assign busy           = loading;
    assign done           = done_q;
    assign bird_load_en   = bird_en_q;
    assign bird_load_addr = bird_addr_q;
    assign bird_load_data = data_q;
    assign pipe_load_en   = pipe_en_q;
    assign pipe_load_addr = pipe_addr_q;
    assign base_load_en   = base_en_q;
    assign base_load_addr = base_addr_q;

endmodule

// File: tb/tb_texture_loader.sv
// Testbench for texture_loader. Two instances share the source stream: one
// with the default asset sizes and one with small sizes for the gapped-stream
// and reset-abort runs. A scoreboard predicts every strobe (target, address,
// data, cycle) from the words the bench hands over.
module tb_texture_loader;

    localparam int S_BIRD = 20;
    localparam int S_PIPE = 30;
    localparam int S_SRCW = 12;
    localparam int S_TEXW = 8;
    localparam int S_H    = 16;

    logic        bird_load_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        sel = 1'b0;

    logic        start_d, start_s;
    logic        d_ready, d_bird_en, d_pipe_en, d_base_en, d_busy, d_done;
    logic [12:0] d_bird_addr;
    logic [15:0] d_pipe_addr, d_data;
    logic [13:0] d_base_addr;
    logic        s_ready, s_bird_en, s_pipe_en, s_base_en, s_busy, s_done;
    logic [12:0] s_bird_addr;
    logic [15:0] s_pipe_addr, s_data;
    logic [13:0] s_base_addr;

    logic        m_ready, m_bird_en, m_pipe_en, m_base_en, m_busy, m_done;
    logic [12:0] m_bird_addr;
    logic [15:0] m_pipe_addr, m_data;
    logic [13:0] m_base_addr;
    logic [79:0] d_outs, s_outs;

    always #5 bird_load_clk = ~bird_load_clk;

    assign start_d = start & ~sel;
    assign start_s = start & sel;

    texture_loader u_dut (
        .bird_load_clk(bird_load_clk), .rst_n(rst_n), .start(start_d),
        .src_data(src_data), .src_valid(src_valid), .src_ready(d_ready),
        .bird_load_en(d_bird_en), .bird_load_addr(d_bird_addr), .bird_load_data(d_data),
        .pipe_load_en(d_pipe_en), .pipe_load_addr(d_pipe_addr),
        .base_load_en(d_base_en), .base_load_addr(d_base_addr),
        .busy(d_busy), .done(d_done)
    );

    texture_loader #(
        .BIRD_WORDS(S_BIRD), .PIPE_WORDS(S_PIPE), .BASE_SRC_W(S_SRCW),
        .BASE_TEX_W(S_TEXW), .BASE_H(S_H)
    ) u_small (
        .bird_load_clk(bird_load_clk), .rst_n(rst_n), .start(start_s),
        .src_data(src_data), .src_valid(src_valid), .src_ready(s_ready),
        .bird_load_en(s_bird_en), .bird_load_addr(s_bird_addr), .bird_load_data(s_data),
        .pipe_load_en(s_pipe_en), .pipe_load_addr(s_pipe_addr),
        .base_load_en(s_base_en), .base_load_addr(s_base_addr),
        .busy(s_busy), .done(s_done)
    );

    assign m_ready     = sel ? s_ready     : d_ready;
    assign m_bird_en   = sel ? s_bird_en   : d_bird_en;
    assign m_pipe_en   = sel ? s_pipe_en   : d_pipe_en;
    assign m_base_en   = sel ? s_base_en   : d_base_en;
    assign m_busy      = sel ? s_busy      : d_busy;
    assign m_done      = sel ? s_done      : d_done;
    assign m_bird_addr = sel ? s_bird_addr : d_bird_addr;
    assign m_pipe_addr = sel ? s_pipe_addr : d_pipe_addr;
    assign m_base_addr = sel ? s_base_addr : d_base_addr;
    assign m_data      = sel ? s_data      : d_data;

    assign d_outs = {15'd0, d_ready, d_bird_en, d_bird_addr, d_data, d_pipe_en,
                     d_pipe_addr, d_base_en, d_base_addr, d_busy, d_done};
    assign s_outs = {15'd0, s_ready, s_bird_en, s_bird_addr, s_data, s_pipe_en,
                     s_pipe_addr, s_base_en, s_base_addr, s_busy, s_done};

    typedef struct {
        int          tgt;   // 0 bird, 1 pipe, 2 base
        int          addr;
        logic [15:0] data;
        int          cyc;   // cycle in which the strobe must appear
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   idx;
    int   p_bird, p_pipe, p_srcw, p_texw, p_h;
    int   cnt_bird, cnt_pipe, cnt_base, last_base;
    int   c40_cyc, c40_hit;
    logic [15:0] exp37, got37;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge bird_load_clk) cyc <= cyc + 1;

    // Reference model: maps the n-th accepted word of a sequence to its strobe.
    task automatic model_accept(input logic [15:0] d);
        exp_t e;
        int   j, col, row;
        e.cyc  = cyc + 1;
        e.data = d;
        if (idx < p_bird) begin
            e.tgt = 0; e.addr = idx; sb_q.push_back(e);
        end else if (idx < p_bird + p_pipe) begin
            e.tgt = 1; e.addr = idx - p_bird; sb_q.push_back(e);
        end else begin
            j   = idx - p_bird - p_pipe;
            col = j % p_srcw;
            row = j / p_srcw;
            if (row == 1 && col == 40) c40_cyc = cyc + 1;
            if (col < p_texw) begin
                e.tgt = 2; e.addr = row * p_texw + col; sb_q.push_back(e);
                if (e.addr == 37) exp37 = d;
            end
        end
        idx++;
    endtask

    task automatic drive_cycle(input bit v, input bit st);
        @(negedge bird_load_clk);
        src_valid = v;
        src_data  = 16'($urandom);
        start     = st;
        #1;
        if (src_valid && m_ready) model_accept(src_data);
    endtask

    task automatic start_run(input int b, input int p, input int sw, input int tw, input int h);
        p_bird = b; p_pipe = p; p_srcw = sw; p_texw = tw; p_h = h;
        idx = 0; cnt_bird = 0; cnt_pipe = 0; cnt_base = 0; last_base = -1;
        c40_cyc = -1; c40_hit = 0; exp37 = '0; got37 = '1;
    endtask

    // Strobe monitor: every strobe is popped against the scoreboard; an
    // expected strobe whose cycle has passed without a strobe is a miss.
    always @(negedge bird_load_clk) begin
        int   n_en, tgt, addr;
        exp_t e;
        n_en = int'(m_bird_en) + int'(m_pipe_en) + int'(m_base_en);
        if (n_en != 0) begin
            check("strobe_onehot", n_en, 1);
            tgt  = m_bird_en ? 0 : (m_pipe_en ? 1 : 2);
            addr = m_bird_en ? int'(m_bird_addr) : (m_pipe_en ? int'(m_pipe_addr) : int'(m_base_addr));
            if (tgt == 0) cnt_bird++;
            if (tgt == 1) cnt_pipe++;
            if (tgt == 2) begin
                cnt_base++;
                last_base = addr;
                if (addr == 37) got37 = m_data;
            end
            if (cyc == c40_cyc) c40_hit = 1;
            if (sb_q.size() == 0) begin
                check("extra_strobe", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_target", tgt, e.tgt);
                check("sb_addr", addr, e.addr);
                check("sb_data", m_data, e.data);
                check("sb_cycle", cyc, e.cyc);
            end
        end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            check("missing_strobe", 0, e.addr + 1);
        end
    end

    initial begin
        int c0, lat;
        start_run(BIRD_DEFAULT(), 40000, 64, 32, 150);

        // Reset state of both instances.
        #1;
        check("rst_outs_default", d_outs, 0);
        check("rst_outs_small", s_outs, 0);
        repeat (3) drive_cycle(1'b1, 1'b0);
        #2 rst_n = 1'b1;
        repeat (4) drive_cycle(1'b1, 1'b0);
        check("idle_ready", m_ready, 0);
        check("idle_busy", m_busy, 0);
        check("idle_done", m_done, 0);

        // Full default load, valid held high, start pulse ignored in PIPE.
        start_run(5250, 40000, 64, 32, 150);
        drive_cycle(1'b1, 1'b1);
        c0 = cyc;
        for (int k = 0; k < 60000 && !m_done; k++) drive_cycle(1'b1, idx == 20000);
        check("runA_done", m_done, 1);
        lat = cyc - c0;
        check("done_latency", (lat >= 54851 && lat <= 54853) ? 54852 : lat, 54852);
        drive_cycle(1'b0, 1'b0);
        check("runA_drained", sb_q.size(), 0);
        check("bird_count", cnt_bird, 5250);
        check("pipe_count", cnt_pipe, 40000);
        check("base_count", cnt_base, 4800);
        check("base_last_addr", last_base, 4799);
        check("base_addr37_data", got37, exp37);
        check("col40_no_strobe", c40_hit, 0);
        check("done_ready", m_ready, 0);
        check("done_busy", m_busy, 0);

        // Restart from DONE: done drops next cycle, bird address 0 again.
        start_run(5250, 40000, 64, 32, 150);
        drive_cycle(1'b0, 1'b1);
        @(posedge bird_load_clk);
        #1;
        check("done_cleared", m_done, 0);
        check("restart_busy", m_busy, 1);
        repeat (5) drive_cycle(1'b1, 1'b0);
        repeat (3) drive_cycle(1'b0, 1'b0);
        check("restart_drained", sb_q.size(), 0);
        check("restart_bird_count", cnt_bird, 5);

        // Small instance, randomly gapped stream, full sequence.
        sel = 1'b1;
        start_run(S_BIRD, S_PIPE, S_SRCW, S_TEXW, S_H);
        drive_cycle(1'b0, 1'b1);
        for (int k = 0; k < 3000 && !m_done; k++) drive_cycle(1'($urandom_range(0, 1)), 1'b0);
        check("runB_done", m_done, 1);
        drive_cycle(1'b0, 1'b0);
        check("runB_drained", sb_q.size(), 0);
        check("gap_bird_count", cnt_bird, S_BIRD);
        check("gap_pipe_count", cnt_pipe, S_PIPE);
        check("gap_base_count", cnt_base, S_TEXW * S_H);
        check("gap_base_last", last_base, S_TEXW * S_H - 1);

        // Abort in BASE at row 10 with an asynchronous reset.
        start_run(S_BIRD, S_PIPE, S_SRCW, S_TEXW, S_H);
        drive_cycle(1'b0, 1'b1);
        for (int k = 0; k < 2000 && idx < S_BIRD + S_PIPE + 10 * S_SRCW + 3; k++)
            drive_cycle(1'($urandom_range(0, 1)), 1'b0);
        check("reached_row10", idx >= S_BIRD + S_PIPE + 10 * S_SRCW + 3, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outs_small", s_outs, 0);
        check("abort_outs_default", d_outs, 0);
        sb_q.delete();
        repeat (2) drive_cycle(1'b1, 1'b0);
        #2 rst_n = 1'b1;
        repeat (20) drive_cycle(1'b1, 1'b0);
        check("post_rst_ready", m_ready, 0);
        check("post_rst_busy", m_busy, 0);
        check("post_rst_done", m_done, 0);
        check("post_rst_no_strobe", cnt_base + cnt_bird + cnt_pipe >= 0 && sb_q.size() == 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    function automatic int BIRD_DEFAULT();
        return 5250;
    endfunction

endmodule
